// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter that pulls bytes from an upstream FIFO with one-cycle read latency.
// Back-to-back bytes are sent with two idle-high cycles (POP, LOAD) between frames.
module uart_tx_fifo #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_read,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } state_e;

    localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        fifo_read_q, fifo_read_d;
    logic        tx_done_q, tx_done_d;
    logic        bit_end;

    assign bit_end = (baud_cnt_q == BIT_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 16'd1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (!fifo_empty) state_d = POP;
            end
            POP: begin
                baud_cnt_d = '0;
                state_d    = LOAD;
            end
            LOAD: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                shift_d    = fifo_data;
                state_d    = START;
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = fifo_empty ? IDLE : POP;
                end
            end
            default: begin
                baud_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered versions line up with it.
        fifo_read_d = (state_d == POP);
        busy_d      = (state_d != IDLE);
        tx_done_d   = (state_d == STOP) && (baud_cnt_d == BIT_LAST);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            fifo_read_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop sees pre-edge values of the others.
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            fifo_read_q <= fifo_read_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign fifo_read = fifo_read_q;
    assign tx_done   = tx_done_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 434 (50 MHz / 115200), giving clocks per serial bit, legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset; one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port fifo_data, input, 8 bits: byte from the upstream FIFO, valid the cycle after a pop.
REQ-005 The block SHALL have port fifo_empty, input, 1 bit: upstream FIFO holds no bytes.
REQ-006 The block SHALL have port fifo_read, output, 1 bit: pop request to the upstream FIFO.
REQ-007 The block SHALL have port tx, output, 1 bit: serial line, 8N1, idle high.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse at the end of each stop bit.

Function
REQ-010 The FSM SHALL have exactly these states: IDLE, POP, LOAD, START, DATA, STOP.
REQ-011 IDLE SHALL go to POP on the first edge where fifo_empty=0, and otherwise stay in IDLE.
REQ-012 fifo_read SHALL be high only while in POP, for exactly one cycle; it is never high on two consecutive cycles and never high when fifo_empty=1 was sampled.
REQ-013 POP SHALL go to LOAD unconditionally; LOAD SHALL capture fifo_data into an 8-bit shift register and go to START.
REQ-014 START SHALL drive tx=0 for BAUD_DIV cycles, then go to DATA.
REQ-015 DATA SHALL shift out 8 bits LSB first, each held BAUD_DIV cycles, using a 3-bit bit counter 0..7, then go to STOP.
REQ-016 STOP SHALL drive tx=1 for BAUD_DIV cycles; on its last cycle tx_done=1.
REQ-017 On STOP exit the FSM SHALL go to POP if fifo_empty=0, else to IDLE, giving back-to-back frames with 2 idle-high cycles between stop and start.
REQ-018 The baud counter SHALL be 16 bits, SHALL clear on every state entry and bit boundary, and a bit SHALL end when count == BAUD_DIV-1.
REQ-019 tx SHALL be registered, glitch-free, and go low at the rising edge that enters START, i.e. 2 edges after the edge entering POP.
REQ-020 A frame SHALL span 10*BAUD_DIV cycles from START entry to STOP exit.
REQ-021 Changes on fifo_empty or fifo_data while in START, DATA or STOP SHALL have no effect on the current frame.

Reset
REQ-022 While rst=1: state=IDLE, tx=1, busy=0, fifo_read=0, tx_done=0, counters=0, shift register=0, all taking effect immediately without a clock edge.
REQ-023 Reset asserted mid-frame SHALL abort the frame, with tx high immediately; the in-flight byte is lost and not re-popped.
REQ-024 After rst deasserts, the first pop SHALL occur no earlier than the first rising edge with rst=0 and fifo_empty=0.

Verification
REQ-025 Reset: BAUD_DIV=4, fifo_empty=1, release rst -> tx=1, busy=0, fifo_read never asserted for 100 cycles.
REQ-026 Single byte: BAUD_DIV=4, one byte 0xA5 presented -> one fifo_read pulse, tx low 2 edges later, bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles, tx_done pulse, then busy=0.
REQ-027 Back-to-back: three bytes 0x00, 0xFF, 0x3C queued -> three frames of 40 cycles each, 2-cycle gap between frames, exactly 3 fifo_read pulses, correct decoded bytes.
REQ-028 Mid-frame reset: assert rst during bit 3 of 0x55 -> tx=1 in the same cycle, busy=0; after release the next queued byte transmits intact.
REQ-029 Empty-boundary: fifo_empty rises during STOP of the last byte -> FSM returns to IDLE, no extra fifo_read; BAUD_DIV=2 run shows 20-cycle frames.
